// File: rtl/conv_pkg.sv
// Shared definitions for the convolution buffer blocks: controller state
// encoding and a constant-foldable ceiling-log2 used to size counters.
package conv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_GAP  = 3'd2,
      ST_READ = 3'd3,
      ST_FIN  = 3'd4
   } conv_state_e;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v = value - 1;
      while (v > 0) begin
         result = result + 1;
         v = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/conv_addr_cnt.sv
// Enable/clear counter that wraps to zero after MAX and flags the terminal
// count combinationally, so the owner can act on the final step in the same cycle.
module conv_addr_cnt #(
   parameter int WIDTH = 8,
   parameter int MAX   = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] count,
   output logic             tc
);

   logic [WIDTH-1:0] count_r;

   // Counter register: clear dominates, then wrap-or-increment on enable.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= {WIDTH{1'b0}};
      end else if (clr) begin
         count_r <= {WIDTH{1'b0}};
      end else if (en) begin
         if (count_r == WIDTH'(MAX)) begin
            count_r <= {WIDTH{1'b0}};
         end else begin
            count_r <= count_r + WIDTH'(1);
         end
      end
   end

   assign count = count_r;
   assign tc    = (count_r == WIDTH'(MAX));

endmodule

// File: rtl/conv_replay_ctrl.sv
// Loads one buffer of input planes into an external RAM, then replays the whole
// buffer once per output channel, with a dilation-sized settling gap before each pass.
module conv_replay_ctrl
   import conv_pkg::*;
#(
   parameter int  IMAGE_WIDTH     = 64,
   parameter int  CHANNEL_NUM_IN  = 64,
   parameter int  CHANNEL_NUM_OUT = 64,
   parameter int  RATE            = 1,
   localparam int TOTAL           = CHANNEL_NUM_IN * IMAGE_WIDTH * IMAGE_WIDTH,
   localparam int GAP             = IMAGE_WIDTH * RATE + RATE,
   localparam int ADDR_WIDTH      = clog2(TOTAL) + 1,
   localparam int PASS_WIDTH      = clog2(CHANNEL_NUM_OUT) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_in,
   input  logic                  ready_in,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  valid_out,
   output logic [PASS_WIDTH-1:0] pass_idx,
   output logic                  pass_last,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow
);

   localparam int GAP_WIDTH = clog2(GAP) + 1;

   conv_state_e           state_r;
   logic [GAP_WIDTH-1:0]  gap_r;
   logic                  valid_out_r;
   logic [PASS_WIDTH-1:0] pass_idx_r;
   logic                  pass_last_r;
   logic                  done_r;
   logic                  overflow_r;

   logic [ADDR_WIDTH-1:0] ptr_s;
   logic                  ptr_tc_s;
   logic                  ptr_en_s;
   logic                  ptr_clr_s;
   logic [PASS_WIDTH-1:0] pass_s;
   logic                  pass_tc_s;
   logic                  pass_en_s;
   logic                  pass_clr_s;
   logic                  wr_s;
   logic                  rd_s;

   conv_addr_cnt #(
      .WIDTH (ADDR_WIDTH),
      .MAX   (TOTAL - 1)
   ) u_ptr_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (ptr_clr_s),
      .en    (ptr_en_s),
      .count (ptr_s),
      .tc    (ptr_tc_s)
   );

   conv_addr_cnt #(
      .WIDTH (PASS_WIDTH),
      .MAX   (CHANNEL_NUM_OUT - 1)
   ) u_pass_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (pass_clr_s),
      .en    (pass_en_s),
      .count (pass_s),
      .tc    (pass_tc_s)
   );

   // RAM strobes and counter controls; the pointer wraps to 0 on its last
   // access, so each pass and the first pass after load start at address 0.
   always_comb begin
      wr_s = 1'b0;
      rd_s = 1'b0;
      case (state_r)
         ST_IDLE, ST_LOAD: wr_s = valid_in;
         ST_READ:          rd_s = ready_in;
         default: begin
            wr_s = 1'b0;
            rd_s = 1'b0;
         end
      endcase
      mem_en = wr_s | rd_s;
      mem_we = wr_s;
      if (wr_s || rd_s) begin
         mem_addr = ptr_s;
      end else begin
         mem_addr = {ADDR_WIDTH{1'b0}};
      end
      ptr_en_s   = wr_s | rd_s;
      ptr_clr_s  = (state_r == ST_FIN);
      pass_en_s  = rd_s & ptr_tc_s & ~pass_tc_s;
      pass_clr_s = (wr_s & ptr_tc_s) | (state_r == ST_FIN);
   end

   // Controller FSM with registered read-side outputs aligned to RAM latency.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         gap_r       <= {GAP_WIDTH{1'b0}};
         valid_out_r <= 1'b0;
         pass_idx_r  <= {PASS_WIDTH{1'b0}};
         pass_last_r <= 1'b0;
         done_r      <= 1'b0;
         overflow_r  <= 1'b0;
      end else begin
         valid_out_r <= rd_s;
         pass_idx_r  <= pass_s;
         pass_last_r <= rd_s & pass_tc_s;
         done_r      <= (state_r == ST_FIN);
         if (valid_in && (state_r == ST_GAP || state_r == ST_READ || state_r == ST_FIN)) begin
            overflow_r <= 1'b1;
         end
         case (state_r)
            ST_IDLE: begin
               if (wr_s) begin
                  state_r <= ptr_tc_s ? ST_GAP : ST_LOAD;
                  gap_r   <= {GAP_WIDTH{1'b0}};
               end
            end
            ST_LOAD: begin
               if (wr_s && ptr_tc_s) begin
                  state_r <= ST_GAP;
                  gap_r   <= {GAP_WIDTH{1'b0}};
               end
            end
            ST_GAP: begin
               if (gap_r == GAP_WIDTH'(GAP - 1)) begin
                  state_r <= ST_READ;
                  gap_r   <= {GAP_WIDTH{1'b0}};
               end else begin
                  gap_r <= gap_r + GAP_WIDTH'(1);
               end
            end
            ST_READ: begin
               if (rd_s && ptr_tc_s) begin
                  state_r <= pass_tc_s ? ST_FIN : ST_GAP;
                  gap_r   <= {GAP_WIDTH{1'b0}};
               end
            end
            ST_FIN: state_r <= ST_IDLE;
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   assign valid_out = valid_out_r;
   assign pass_idx  = pass_idx_r;
   assign pass_last = pass_last_r;
   assign done      = done_r;
   assign overflow  = overflow_r;
   assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_conv_replay_ctrl.sv
// Self-checking bench for conv_replay_ctrl with a 4x4x2 buffer replayed 3 times;
// expected read timing is derived from the load end and the recorded ready_in history.
module tb_conv_replay_ctrl;

   localparam int IW    = 4;
   localparam int CI    = 2;
   localparam int CO    = 3;
   localparam int RT    = 1;
   localparam int TOTAL = CI * IW * IW;
   localparam int GAPC  = IW * RT + RT;
   localparam int NRD   = TOTAL * CO;

   logic       clk = 1'b0;
   logic       reset;
   logic       valid_in;
   logic       ready_in;
   logic       mem_en;
   logic       mem_we;
   logic [5:0] mem_addr;
   logic       valid_out;
   logic [2:0] pass_idx;
   logic       pass_last;
   logic       busy;
   logic       done;
   logic       overflow;

   int checks   = 0;
   int failures = 0;

   int cyc = 0;
   bit ready_hist [0:8191];
   int wr_addr_q[$];
   int wr_cyc_q[$];
   int rd_addr_q[$];
   int rd_cyc_q[$];
   int vo_cyc_q[$];
   int vo_pass_q[$];
   int vo_last_q[$];
   int done_cnt;
   int done_cyc;
   int bad_idle;

   int exp_cyc[$];
   int exp_addr[$];
   int exp_pass[$];

   conv_replay_ctrl #(
      .IMAGE_WIDTH     (IW),
      .CHANNEL_NUM_IN  (CI),
      .CHANNEL_NUM_OUT (CO),
      .RATE            (RT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (valid_in),
      .ready_in  (ready_in),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .valid_out (valid_out),
      .pass_idx  (pass_idx),
      .pass_last (pass_last),
      .busy      (busy),
      .done      (done),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   // Mid-cycle monitor recording every RAM access, valid_out beat and done pulse.
   always @(negedge clk) begin
      cyc = cyc + 1;
      ready_hist[cyc % 8192] = ready_in;
      if (mem_en && mem_we) begin
         wr_addr_q.push_back(int'(mem_addr));
         wr_cyc_q.push_back(cyc);
      end
      if (mem_en && !mem_we) begin
         rd_addr_q.push_back(int'(mem_addr));
         rd_cyc_q.push_back(cyc);
      end
      if (valid_out) begin
         vo_cyc_q.push_back(cyc);
         vo_pass_q.push_back(int'(pass_idx));
         vo_last_q.push_back(int'(pass_last));
      end
      if (done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
      if (!mem_en && (mem_we || mem_addr != 6'd0)) bad_idle = bad_idle + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      wr_addr_q.delete(); wr_cyc_q.delete();
      rd_addr_q.delete(); rd_cyc_q.delete();
      vo_cyc_q.delete(); vo_pass_q.delete(); vo_last_q.delete();
      done_cnt = 0; done_cyc = 0; bad_idle = 0;
   endtask

   task automatic do_load(input int spacing);
      for (int i = 0; i < TOTAL; i++) begin
         valid_in = 1'b1;
         tick();
         valid_in = 1'b0;
         repeat (spacing - 1) tick();
      end
   endtask

   // mode 0: ready held high, 1: toggling, 2: random
   task automatic run_until_done(input int mode, input int budget, output bit ok);
      bit [31:0] rnd;
      ok = 1'b0;
      for (int n = 0; n < budget; n++) begin
         rnd = $urandom;
         case (mode)
            0:       ready_in = 1'b1;
            1:       ready_in = (n % 2 == 0);
            default: ready_in = rnd[0];
         endcase
         tick();
         if (done_cnt > 0) begin
            ok = 1'b1;
            break;
         end
      end
      ready_in = 1'b1;
      repeat (4) tick();
   endtask

   // Reference schedule: GAPC idle cycles after the last write and after each
   // non-final pass; inside a pass one address is issued per ready cycle.
   task automatic build_expected(input int last_wr);
      int t;
      exp_cyc.delete(); exp_addr.delete(); exp_pass.delete();
      t = last_wr + GAPC + 1;
      for (int p = 0; p < CO; p++) begin
         for (int a = 0; a < TOTAL; a++) begin
            for (int g = 0; g < 1000 && !ready_hist[t % 8192]; g++) t = t + 1;
            exp_cyc.push_back(t);
            exp_addr.push_back(a);
            exp_pass.push_back(p);
            t = t + 1;
         end
         t = t + GAPC;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; valid_in = 1'b0; ready_in = 1'b0;
      repeat (3) tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem: en=%0b we=%0b expected 0 0", mem_en, mem_we); end
      checks++; if (mem_addr !== 6'd0) begin failures++; $display("FAIL reset_addr: got %0d expected 0", mem_addr); end
      checks++; if (valid_out !== 1'b0 || pass_last !== 1'b0 || pass_idx !== 3'd0) begin failures++; $display("FAIL reset_out: vo=%0b last=%0b idx=%0d expected 0 0 0", valid_out, pass_last, pass_idx); end
      checks++; if (done !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL reset_flags: done=%0b ovf=%0b expected 0 0", done, overflow); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      bit ok;
      clear_mon();
      ready_in = 1'b1;
      for (int i = 0; i < TOTAL; i++) begin
         valid_in = 1'b1;
         tick();
         if (i == 0) begin
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy_rise: got %0b expected 1", busy); end
         end
      end
      valid_in = 1'b0;
      run_until_done(0, 1000, ok);
      checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout: done seen %0d expected 1", done_cnt); end
      checks++; if (wr_addr_q.size() != TOTAL) begin failures++; $display("FAIL b2b_wr_count: got %0d expected %0d", wr_addr_q.size(), TOTAL); end
      for (int i = 0; i < wr_addr_q.size(); i++) begin
         checks++; if (wr_addr_q[i] != i || wr_cyc_q[i] != wr_cyc_q[0] + i) begin failures++; $display("FAIL b2b_wr[%0d]: addr %0d cyc+%0d expected %0d", i, wr_addr_q[i], wr_cyc_q[i] - wr_cyc_q[0], i); end
      end
      if (wr_cyc_q.size() > 0) build_expected(wr_cyc_q[wr_cyc_q.size() - 1]);
      checks++; if (rd_cyc_q.size() > 0 && wr_cyc_q.size() > 0 && rd_cyc_q[0] - wr_cyc_q[wr_cyc_q.size() - 1] != GAPC + 1) begin failures++; $display("FAIL b2b_gap: first read after %0d cycles expected %0d", rd_cyc_q[0] - wr_cyc_q[wr_cyc_q.size() - 1], GAPC + 1); end
      checks++; if (rd_addr_q.size() != NRD || vo_cyc_q.size() != NRD) begin failures++; $display("FAIL b2b_counts: reads %0d valid_out %0d expected %0d", rd_addr_q.size(), vo_cyc_q.size(), NRD); end
      for (int i = 0; i < rd_addr_q.size() && i < exp_addr.size(); i++) begin
         checks++; if (rd_addr_q[i] != exp_addr[i] || rd_cyc_q[i] != exp_cyc[i]) begin failures++; $display("FAIL b2b_rd[%0d]: addr %0d cyc %0d expected %0d %0d", i, rd_addr_q[i], rd_cyc_q[i], exp_addr[i], exp_cyc[i]); end
      end
      for (int i = 0; i < vo_cyc_q.size() && i < exp_cyc.size(); i++) begin
         checks++; if (vo_cyc_q[i] != exp_cyc[i] + 1 || vo_pass_q[i] != exp_pass[i] || vo_last_q[i] != int'(exp_pass[i] == CO - 1)) begin failures++; $display("FAIL b2b_vo[%0d]: cyc %0d pass %0d last %0d expected %0d %0d %0d", i, vo_cyc_q[i], vo_pass_q[i], vo_last_q[i], exp_cyc[i] + 1, exp_pass[i], int'(exp_pass[i] == CO - 1)); end
      end
      checks++; if (done_cnt != 1 || (exp_cyc.size() > 0 && done_cyc != exp_cyc[exp_cyc.size() - 1] + 2)) begin failures++; $display("FAIL b2b_done: pulses %0d cyc %0d expected 1 at last read+2", done_cnt, done_cyc); end
      checks++; if (busy !== 1'b0 || overflow !== 1'b0 || bad_idle != 0) begin failures++; $display("FAIL b2b_end: busy %0b ovf %0b idle_strobes %0d expected 0 0 0", busy, overflow, bad_idle); end
   endtask

   task automatic test_backpressure(input int mode);
      bit ok;
      clear_mon();
      ready_in = 1'b0;
      do_load(1);
      run_until_done(mode, 3000, ok);
      checks++; if (!ok) begin failures++; $display("FAIL bp%0d_timeout: done seen %0d expected 1", mode, done_cnt); end
      if (wr_cyc_q.size() > 0) build_expected(wr_cyc_q[wr_cyc_q.size() - 1]);
      checks++; if (rd_addr_q.size() != NRD || vo_cyc_q.size() != NRD) begin failures++; $display("FAIL bp%0d_counts: reads %0d valid_out %0d expected %0d", mode, rd_addr_q.size(), vo_cyc_q.size(), NRD); end
      for (int i = 0; i < rd_addr_q.size() && i < exp_addr.size(); i++) begin
         checks++; if (rd_addr_q[i] != exp_addr[i] || rd_cyc_q[i] != exp_cyc[i]) begin failures++; $display("FAIL bp%0d_rd[%0d]: addr %0d cyc %0d expected %0d %0d", mode, i, rd_addr_q[i], rd_cyc_q[i], exp_addr[i], exp_cyc[i]); end
      end
      for (int i = 0; i < vo_cyc_q.size() && i < rd_cyc_q.size(); i++) begin
         checks++; if (vo_cyc_q[i] != rd_cyc_q[i] + 1) begin failures++; $display("FAIL bp%0d_latency[%0d]: valid_out cyc %0d expected %0d", mode, i, vo_cyc_q[i], rd_cyc_q[i] + 1); end
      end
      checks++; if (done_cnt != 1 || bad_idle != 0) begin failures++; $display("FAIL bp%0d_done: pulses %0d idle_strobes %0d expected 1 0", mode, done_cnt, bad_idle); end
   endtask

   task automatic test_gapped_load();
      bit ok;
      clear_mon();
      ready_in = 1'b1;
      for (int i = 0; i < TOTAL; i++) begin
         valid_in = 1'b1;
         tick();
         valid_in = 1'b0;
         repeat (2) tick();
         if (i < TOTAL - 1) begin
            checks++; if (busy !== 1'b1 || rd_addr_q.size() != 0) begin failures++; $display("FAIL gl_hold[%0d]: busy %0b reads %0d expected 1 0", i, busy, rd_addr_q.size()); end
         end
      end
      run_until_done(0, 1000, ok);
      checks++; if (!ok) begin failures++; $display("FAIL gl_timeout: done seen %0d expected 1", done_cnt); end
      checks++; if (wr_addr_q.size() != TOTAL) begin failures++; $display("FAIL gl_wr_count: got %0d expected %0d", wr_addr_q.size(), TOTAL); end
      for (int i = 0; i < wr_addr_q.size(); i++) begin
         checks++; if (wr_addr_q[i] != i || wr_cyc_q[i] != wr_cyc_q[0] + 3 * i) begin failures++; $display("FAIL gl_wr[%0d]: addr %0d cyc+%0d expected %0d +%0d", i, wr_addr_q[i], wr_cyc_q[i] - wr_cyc_q[0], i, 3 * i); end
      end
      if (wr_cyc_q.size() > 0) build_expected(wr_cyc_q[wr_cyc_q.size() - 1]);
      checks++; if (rd_addr_q.size() != NRD) begin failures++; $display("FAIL gl_rd_count: got %0d expected %0d", rd_addr_q.size(), NRD); end
      for (int i = 0; i < rd_addr_q.size() && i < exp_addr.size(); i++) begin
         checks++; if (rd_addr_q[i] != exp_addr[i] || rd_cyc_q[i] != exp_cyc[i]) begin failures++; $display("FAIL gl_rd[%0d]: addr %0d cyc %0d expected %0d %0d", i, rd_addr_q[i], rd_cyc_q[i], exp_addr[i], exp_cyc[i]); end
      end
   endtask

   task automatic test_overflow();
      bit ok;
      clear_mon();
      ready_in = 1'b1;
      do_load(1);
      tick();
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      checks++; if (overflow !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL ovf_set: ovf %0b busy %0b expected 1 1", overflow, busy); end
      run_until_done(0, 1000, ok);
      checks++; if (!ok || done_cnt != 1) begin failures++; $display("FAIL ovf_done: pulses %0d expected 1", done_cnt); end
      checks++; if (wr_addr_q.size() != TOTAL) begin failures++; $display("FAIL ovf_no_write: writes %0d expected %0d", wr_addr_q.size(), TOTAL); end
      checks++; if (rd_addr_q.size() != NRD) begin failures++; $display("FAIL ovf_reads: got %0d expected %0d", rd_addr_q.size(), NRD); end
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %0b expected 1", overflow); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %0b expected 0", overflow); end
      tick();
   endtask

   task automatic test_mid_reset();
      bit ok;
      bit hit;
      clear_mon();
      ready_in = 1'b1;
      do_load(1);
      hit = 1'b0;
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         #1;
         if (rd_addr_q.size() >= TOTAL + 18) begin
            hit = 1'b1;
            break;
         end
      end
      reset = 1'b1;
      checks++; if (!hit || rd_addr_q[TOTAL + 17] != 17) begin failures++; $display("FAIL mr_reach: reads %0d expected pass1 addr 17", rd_addr_q.size()); end
      tick();
      checks++; if (busy !== 1'b0 || valid_out !== 1'b0 || mem_en !== 1'b0) begin failures++; $display("FAIL mr_idle: busy %0b vo %0b en %0b expected 0 0 0", busy, valid_out, mem_en); end
      reset = 1'b0;
      tick();
      clear_mon();
      do_load(1);
      run_until_done(0, 1000, ok);
      checks++; if (wr_addr_q.size() != TOTAL || wr_addr_q[0] != 0) begin failures++; $display("FAIL mr_reload: writes %0d first %0d expected %0d 0", wr_addr_q.size(), wr_addr_q.size() > 0 ? wr_addr_q[0] : -1, TOTAL); end
      checks++; if (!ok || done_cnt != 1 || vo_cyc_q.size() != NRD) begin failures++; $display("FAIL mr_replay: done %0d valid_out %0d expected 1 %0d", done_cnt, vo_cyc_q.size(), NRD); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_backpressure(1);
      test_backpressure(2);
      test_gapped_load();
      test_overflow();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
